// File: rtl/phy_codec_arbiter_if.sv
// Channel-side and codec-side signals of the shared line-codec arbiter.
// The slave modport is the arbiter; the master modport is the PHY channels plus the codec.
interface phy_codec_arbiter_if #(
  parameter int NCH    = 4,
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 10
);
  logic [NCH-1:0]        req_valid;
  logic [NCH*DW_IN-1:0]  req_data;
  logic [NCH-1:0]        req_kin;
  logic [NCH-1:0]        req_force;
  logic [NCH-1:0]        req_ready;
  logic [NCH-1:0]        ch_clr;
  logic [NCH-1:0]        rsp_valid;
  logic [NCH*DW_OUT-1:0] rsp_data;
  logic                  busy;
  logic                  cdc_ce;
  logic [DW_IN-1:0]      cdc_din;
  logic                  cdc_kin;
  logic                  cdc_force_code;
  logic                  cdc_disp_in;
  logic [DW_OUT-1:0]     cdc_dout;
  logic                  cdc_disp_out;

  modport slave (
    input  req_valid, req_data, req_kin, req_force, ch_clr, cdc_dout, cdc_disp_out,
    output req_ready, rsp_valid, rsp_data, busy,
           cdc_ce, cdc_din, cdc_kin, cdc_force_code, cdc_disp_in
  );
  modport master (
    output req_valid, req_data, req_kin, req_force, ch_clr, cdc_dout, cdc_disp_out,
    input  req_ready, rsp_valid, rsp_data, busy,
           cdc_ce, cdc_din, cdc_kin, cdc_force_code, cdc_disp_in
  );
endinterface

// File: rtl/phy_codec_arbiter.sv
// Shares one fixed-latency line codec among NCH PHY channels, round-robin.
// Each channel keeps its own running disparity and a one-entry holding register.
module phy_codec_arbiter_lane #(
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 10
) (
  input  logic              clk_40mhz,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [DW_IN-1:0]  req_data,
  input  logic              req_kin,
  input  logic              req_force,
  input  logic              ch_clr,
  input  logic              gnt,
  input  logic              ret,
  input  logic [DW_OUT-1:0] dout,
  input  logic              disp_out,
  output logic              pending,
  output logic              inflight,
  output logic              disp,
  output logic [DW_IN-1:0]  hdata,
  output logic              hkin,
  output logic              hforce,
  output logic              rsp_valid,
  output logic [DW_OUT-1:0] rsp_data
);
  logic kill;
  logic ok;

  // a clear landing on the return cycle discards that result too
  assign ok = ret & ~(kill | ch_clr);

  always_ff @(posedge clk_40mhz or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      inflight  <= 1'b0;
      kill      <= 1'b0;
      disp      <= 1'b0;
      hdata     <= '0;
      hkin      <= 1'b0;
      hforce    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= ok;
      if (ok) rsp_data <= dout;

      if (ch_clr) pending <= 1'b0;
      else if (req_valid && !pending) begin
        pending <= 1'b1;
        hdata   <= req_data;
        hkin    <= req_kin;
        hforce  <= req_force;
      end else if (gnt) pending <= 1'b0;

      if (gnt) inflight <= 1'b1;
      else if (ret) inflight <= 1'b0;

      if (ret) kill <= 1'b0;
      else if (ch_clr && (inflight || gnt)) kill <= 1'b1;

      if (ch_clr) disp <= 1'b0;
      else if (ok) disp <= disp_out;
    end
  end
endmodule

module phy_codec_arbiter #(
  parameter int NCH    = 4,
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 10,
  parameter int LAT    = 2
) (
  input logic              clk_40mhz,
  input logic              reset,
  phy_codec_arbiter_if.slave bus
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]             pending, inflight, disp, hkin, hforce, rsp_vld;
  logic [NCH-1:0]             eligible, gnt_oh, ret_oh;
  logic [NCH-1:0][DW_IN-1:0]  req_d, hdata;
  logic [NCH-1:0][DW_OUT-1:0] rsp_d;
  logic [CW-1:0]              rr, gnt_idx;
  logic                       gnt_vld;
  logic [LAT:1]               vld_pipe;
  logic [LAT:1][CW-1:0]       ch_pipe;

  assign req_d    = bus.req_data;
  assign eligible = pending & ~inflight;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_vld && eligible[(int'(rr) + k) % NCH]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'((int'(rr) + k) % NCH);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    ret_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    if (vld_pipe[LAT]) ret_oh[ch_pipe[LAT]] = 1'b1;
  end

  always_ff @(posedge clk_40mhz or posedge reset) begin
    if (reset) begin
      rr       <= '0;
      vld_pipe <= '0;
      ch_pipe  <= '0;
    end else begin
      if (gnt_vld) rr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
      vld_pipe[1] <= gnt_vld;
      ch_pipe[1]  <= gnt_idx;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        ch_pipe[s]  <= ch_pipe[s-1];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    phy_codec_arbiter_lane #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) u_lane (
      .clk_40mhz (clk_40mhz),
      .reset     (reset),
      .req_valid (bus.req_valid[i]),
      .req_data  (req_d[i]),
      .req_kin   (bus.req_kin[i]),
      .req_force (bus.req_force[i]),
      .ch_clr    (bus.ch_clr[i]),
      .gnt       (gnt_oh[i]),
      .ret       (ret_oh[i]),
      .dout      (bus.cdc_dout),
      .disp_out  (bus.cdc_disp_out),
      .pending   (pending[i]),
      .inflight  (inflight[i]),
      .disp      (disp[i]),
      .hdata     (hdata[i]),
      .hkin      (hkin[i]),
      .hforce    (hforce[i]),
      .rsp_valid (rsp_vld[i]),
      .rsp_data  (rsp_d[i])
    );
  end

  assign bus.req_ready = ~pending;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = rsp_d;
  assign bus.busy      = |(pending | inflight);

  always_comb begin
    bus.cdc_ce         = 1'b0;
    bus.cdc_din        = '0;
    bus.cdc_kin        = 1'b0;
    bus.cdc_force_code = 1'b0;
    bus.cdc_disp_in    = 1'b0;
    if (gnt_vld) begin
      bus.cdc_ce         = 1'b1;
      bus.cdc_din        = hdata[gnt_idx];
      bus.cdc_kin        = hkin[gnt_idx];
      bus.cdc_force_code = hforce[gnt_idx];
      bus.cdc_disp_in    = hforce[gnt_idx] ? 1'b0 : disp[gnt_idx];
    end
  end
endmodule

// File: tb/tb_phy_codec_arbiter.sv
// Directed bench for phy_codec_arbiter with a two-cycle behavioural 8b/10b codec.
`timescale 1ns/100ps
module tb_phy_codec_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  phy_codec_arbiter_if #(.NCH(4), .DW_IN(8), .DW_OUT(10)) bus ();
  phy_codec_arbiter #(.NCH(4), .DW_IN(8), .DW_OUT(10), .LAT(2)) dut (
    .clk_40mhz (clk),
    .reset     (rst),
    .bus       (bus)
  );

  always #12.5 clk = ~clk;

  // {disp_out, code}, code bits abcdei_fghj with a as MSB
  function automatic logic [10:0] enc(input logic [7:0] d, input logic k, input logic rd);
    if (k && d == 8'hBC) return rd ? {1'b0, 10'h305} : {1'b1, 10'h0FA};
    if (!k && d == 8'h00) return rd ? {1'b1, 10'h18B} : {1'b0, 10'h274};
    return {rd, 2'b01, d};  // stand-in for characters outside the small table
  endfunction

  logic [10:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= bus.cdc_ce ? enc(bus.cdc_din, bus.cdc_kin, bus.cdc_disp_in) : 11'd0;
    s2 <= s1;
  end
  assign bus.cdc_dout     = s2[9:0];
  assign bus.cdc_disp_out = s2[10];

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid = '0; bus.req_data = '0; bus.req_kin = '0;
    bus.req_force = '0; bus.ch_clr = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    step(); step();
    vecs++; if (bus.req_ready !== 4'hF) begin errs++; $display("FAIL reset_ready got=%0h exp=f", bus.req_ready); end
    vecs++; if (bus.cdc_ce !== 1'b0) begin errs++; $display("FAIL reset_ce got=%0h exp=0", bus.cdc_ce); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
    vecs++; if (bus.rsp_valid !== 4'h0) begin errs++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
    vecs++; if (bus.rsp_data !== 40'h0) begin errs++; $display("FAIL reset_rsp_data got=%0h exp=0", bus.rsp_data); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    bus.req_valid = 4'b0001; bus.req_data[7:0] = 8'hBC; bus.req_kin = 4'b0001;
    step();
    idle_inputs();
    vecs++; if (bus.cdc_ce !== 1'b1) begin errs++; $display("FAIL single_ce got=%0h exp=1", bus.cdc_ce); end
    vecs++; if (bus.cdc_din !== 8'hBC) begin errs++; $display("FAIL single_din got=%0h exp=bc", bus.cdc_din); end
    vecs++; if (bus.cdc_kin !== 1'b1) begin errs++; $display("FAIL single_kin got=%0h exp=1", bus.cdc_kin); end
    vecs++; if (bus.cdc_disp_in !== 1'b0) begin errs++; $display("FAIL single_disp_in got=%0h exp=0", bus.cdc_disp_in); end
    vecs++; if (bus.req_ready !== 4'b1110) begin errs++; $display("FAIL single_ready got=%0h exp=e", bus.req_ready); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL single_busy got=%0h exp=1", bus.busy); end
    step();
    vecs++; if (bus.cdc_ce !== 1'b0) begin errs++; $display("FAIL single_ce_once got=%0h exp=0", bus.cdc_ce); end
    step();
    vecs++; if (bus.rsp_valid !== 4'h0) begin errs++; $display("FAIL single_rsp_early got=%0h exp=0", bus.rsp_valid); end
    step();
    vecs++; if (bus.rsp_valid !== 4'b0001) begin errs++; $display("FAIL single_rsp_valid got=%0h exp=1", bus.rsp_valid); end
    vecs++; if (bus.rsp_data[9:0] !== 10'h0FA) begin errs++; $display("FAIL single_rsp_data got=%0h exp=0fa", bus.rsp_data[9:0]); end
    vecs++; if (dut.disp[0] !== 1'b1) begin errs++; $display("FAIL single_disp0 got=%0h exp=1", dut.disp[0]); end
    step();
    vecs++; if (bus.rsp_valid !== 4'h0) begin errs++; $display("FAIL single_rsp_pulse got=%0h exp=0", bus.rsp_valid); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_idle got=%0h exp=0", bus.busy); end
  endtask

  task automatic test_all_four;
    logic [3:0] exp_v;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req_valid = 4'hF; bus.req_data = 32'h13121110;
    step();
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      exp_v = (c >= 3 && c < 7) ? 4'(1 << (c - 3)) : 4'h0;
      vecs++; if (bus.cdc_ce !== (c < 4)) begin errs++; $display("FAIL rr_ce[%0d] got=%0h exp=%0h", c, bus.cdc_ce, c < 4); end
      if (c < 4) begin
        vecs++; if (bus.cdc_din !== 8'(8'h10 + c)) begin errs++; $display("FAIL rr_order[%0d] got=%0h exp=%0h", c, bus.cdc_din, 8'h10 + c); end
      end
      vecs++; if (bus.rsp_valid !== exp_v) begin errs++; $display("FAIL rr_rsp[%0d] got=%0h exp=%0h", c, bus.rsp_valid, exp_v); end
      step();
    end
    vecs++; if (bus.rsp_data !== {10'h113, 10'h112, 10'h111, 10'h110}) begin
      errs++; $display("FAIL rr_data got=%0h exp=%0h", bus.rsp_data, {10'h113, 10'h112, 10'h111, 10'h110}); end
  endtask

  task automatic test_back_to_back;
    logic first_disp;
    bus.req_valid = 4'b0100; bus.req_data = 32'h0;
    step();
    vecs++; if (bus.cdc_ce !== 1'b1) begin errs++; $display("FAIL b2b_first_ce got=%0h exp=1", bus.cdc_ce); end
    vecs++; if (bus.cdc_disp_in !== 1'b0) begin errs++; $display("FAIL b2b_first_disp got=%0h exp=0", bus.cdc_disp_in); end
    step();
    vecs++; if (bus.req_ready[2] !== 1'b1) begin errs++; $display("FAIL b2b_ready_inflight got=%0h exp=1", bus.req_ready[2]); end
    vecs++; if (bus.cdc_ce !== 1'b0) begin errs++; $display("FAIL b2b_no_issue_c1 got=%0h exp=0", bus.cdc_ce); end
    step();
    idle_inputs();
    vecs++; if (dut.pending[2] !== 1'b1) begin errs++; $display("FAIL b2b_second_held got=%0h exp=1", dut.pending[2]); end
    vecs++; if (bus.cdc_ce !== 1'b0) begin errs++; $display("FAIL b2b_no_issue_c2 got=%0h exp=0", bus.cdc_ce); end
    vecs++; if (bus.cdc_dout !== 10'h274) begin errs++; $display("FAIL b2b_codec_out got=%0h exp=274", bus.cdc_dout); end
    first_disp = bus.cdc_disp_out;
    step();
    vecs++; if (bus.rsp_valid !== 4'b0100) begin errs++; $display("FAIL b2b_rsp1 got=%0h exp=4", bus.rsp_valid); end
    vecs++; if (bus.cdc_ce !== 1'b1) begin errs++; $display("FAIL b2b_second_ce got=%0h exp=1", bus.cdc_ce); end
    vecs++; if (bus.cdc_disp_in !== first_disp) begin errs++; $display("FAIL b2b_second_disp got=%0h exp=%0h", bus.cdc_disp_in, first_disp); end
    step(); step(); step();
    vecs++; if (bus.rsp_valid !== 4'b0100) begin errs++; $display("FAIL b2b_rsp2 got=%0h exp=4", bus.rsp_valid); end
    vecs++; if (bus.rsp_data[29:20] !== 10'h274) begin errs++; $display("FAIL b2b_rsp2_data got=%0h exp=274", bus.rsp_data[29:20]); end
  endtask

  task automatic test_clear;
    bus.req_valid = 4'b0010; bus.req_data = 32'h0000BC00; bus.req_kin = 4'b0010;
    step();
    idle_inputs();
    vecs++; if (bus.cdc_ce !== 1'b1 || bus.cdc_din !== 8'hBC) begin
      errs++; $display("FAIL clr_grant got=%0h/%0h exp=1/bc", bus.cdc_ce, bus.cdc_din); end
    step();
    bus.ch_clr = 4'b0010;
    step();
    bus.ch_clr = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      vecs++; if (bus.rsp_valid[1] !== 1'b0) begin errs++; $display("FAIL clr_no_rsp[%0d] got=%0h exp=0", c, bus.rsp_valid[1]); end
      step();
    end
    vecs++; if (dut.disp[1] !== 1'b0) begin errs++; $display("FAIL clr_disp got=%0h exp=0", dut.disp[1]); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL clr_busy got=%0h exp=0", bus.busy); end
    bus.req_valid = 4'b0010; bus.ch_clr = 4'b0010; bus.req_data = 32'h00005500;
    step();
    idle_inputs();
    vecs++; if (dut.pending[1] !== 1'b0) begin errs++; $display("FAIL clr_prio_pending got=%0h exp=0", dut.pending[1]); end
    vecs++; if (bus.req_ready[1] !== 1'b1) begin errs++; $display("FAIL clr_prio_ready got=%0h exp=1", bus.req_ready[1]); end
    vecs++; if (bus.cdc_ce !== 1'b0) begin errs++; $display("FAIL clr_prio_ce got=%0h exp=0", bus.cdc_ce); end
  endtask

  task automatic test_force;
    bus.req_valid = 4'b1000; bus.req_data = 32'hBC000000; bus.req_kin = 4'b1000;
    step();
    idle_inputs();
    step(); step(); step();
    vecs++; if (bus.rsp_data[39:30] !== 10'h0FA) begin errs++; $display("FAIL force_pre_data got=%0h exp=0fa", bus.rsp_data[39:30]); end
    vecs++; if (dut.disp[3] !== 1'b1) begin errs++; $display("FAIL force_pre_disp got=%0h exp=1", dut.disp[3]); end
    bus.req_valid = 4'b1000; bus.req_data = 32'h0; bus.req_force = 4'b1000;
    step();
    idle_inputs();
    vecs++; if (bus.cdc_ce !== 1'b1) begin errs++; $display("FAIL force_ce got=%0h exp=1", bus.cdc_ce); end
    vecs++; if (bus.cdc_force_code !== 1'b1) begin errs++; $display("FAIL force_code got=%0h exp=1", bus.cdc_force_code); end
    vecs++; if (bus.cdc_disp_in !== 1'b0) begin errs++; $display("FAIL force_disp_in got=%0h exp=0", bus.cdc_disp_in); end
    step(); step(); step();
    vecs++; if (bus.rsp_data[39:30] !== 10'h274) begin errs++; $display("FAIL force_data got=%0h exp=274", bus.rsp_data[39:30]); end
  endtask

  task automatic test_reset_midflight;
    bus.req_valid = 4'b0011; bus.req_data = 32'h00001110;
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    #1;
    vecs++; if (bus.rsp_valid !== 4'h0) begin errs++; $display("FAIL rstmid_rsp_valid got=%0h exp=0", bus.rsp_valid); end
    vecs++; if (bus.rsp_data !== 40'h0) begin errs++; $display("FAIL rstmid_rsp_data got=%0h exp=0", bus.rsp_data); end
    vecs++; if (bus.cdc_ce !== 1'b0) begin errs++; $display("FAIL rstmid_ce got=%0h exp=0", bus.cdc_ce); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%0h exp=0", bus.busy); end
    vecs++; if (bus.req_ready !== 4'hF) begin errs++; $display("FAIL rstmid_ready got=%0h exp=f", bus.req_ready); end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      vecs++; if (bus.rsp_valid !== 4'h0) begin errs++; $display("FAIL rstmid_no_rsp[%0d] got=%0h exp=0", c, bus.rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_clear();
    test_force();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
